mips_mc_core: RTL

Multi-cycle MIPS-subset core and the successor to the single-cycle top. It executes one instruction over 3–5 states of an internal FSM and shares one register file and one ALU across those states. It also replaces separate instruction and data memories with a single unified memory port that uses a req/ready handshake, so it tolerates wait states. Debug outputs match the single-cycle top, so existing benches and waveform views still apply.

---
 rtl/mips_mc_pkg.sv | 77 +++++++
 rtl/mips_mc_regfile.sv | 32 +++
 rtl/mips_mc_core.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: FSM states,
// instruction field encodings, ALU-control codes and small decode helpers.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_MEMWB,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Same 3-bit codes as the single-cycle control unit.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        logic [2:0] ctrl;
        case (funct)
            FN_SUB:  ctrl = ALU_SUB;
            FN_AND:  ctrl = ALU_AND;
            FN_OR:   ctrl = ALU_OR;
            FN_SLT:  ctrl = ALU_SLT;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        logic ok;
        case (opcode)
            OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] alu_eval(input logic [2:0] ctrl, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] y;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, $0 hardwired to zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // NOTE: the array is reset explicitly because every register must read zero after reset;
    // this keeps it in flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core: one shared ALU and register file, unified
// memory port with req/ready handshake that tolerates wait states.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result,
    output logic        trap
);

    state_t      state, next_state;
    logic [31:0] pc, ir, a_q, b_q, alu_out, mdr;
    logic [31:0] rd1, rd2, imm_sext;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_ctrl;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    mips_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        next_state = state;
        alu_a      = pc;
        alu_b      = 32'd4;
        alu_ctrl   = ALU_ADD;
        rf_we      = 1'b0;
        rf_wa      = rt;
        rf_wd      = alu_out;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_b = {imm_sext[29:0], 2'b00};
                if (!is_legal(opcode, funct)) begin
                    next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_RTYPE:     next_state = S_EXEC;
                        OP_BEQ:       next_state = S_BRANCH;
                        OP_ADDI:      next_state = S_ADDIEX;
                        OP_J:         next_state = S_JUMP;
                        default:      next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_a      = a_q;
                alu_b      = imm_sext;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) next_state = S_FETCH;
            end
            S_MEMWB: begin
                rf_we      = 1'b1;
                rf_wd      = mdr;
                next_state = S_FETCH;
            end
            S_EXEC: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_ctrl   = funct_to_alu(funct);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we      = 1'b1;
                rf_wa      = rd;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_a      = a_q;
                alu_b      = imm_sext;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we      = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH, S_JUMP: next_state = S_FETCH;
            default: next_state = state;
        endcase
    end

    assign alu_y = alu_eval(alu_ctrl, alu_a, alu_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= alu_y;
                    end
                end
                S_DECODE: begin
                    a_q     <= rd1;
                    b_q     <= rd2;
                    alu_out <= alu_y;
                end
                S_MEMADR, S_EXEC, S_ADDIEX: alu_out <= alu_y;
                S_MEMRD: begin
                    if (mem_ready) mdr <= mem_rdata;
                end
                S_BRANCH: begin
                    if (a_q == b_q) pc <= alu_out;
                end
                S_JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Gating with rst_n drops an in-flight request the moment reset asserts.
    assign mem_req    = rst_n && (state inside {S_FETCH, S_MEMRD, S_MEMWR});
    assign mem_we     = (state == S_MEMWR);
    assign mem_addr   = (state == S_FETCH) ? {pc[31:2], 2'b00} : {alu_out[31:2], 2'b00};
    assign mem_wdata  = b_q;
    assign pc_out     = pc;
    assign alu_result = alu_out;
    assign trap       = (state == S_TRAP);

endmodule
